signal_analyzer: RTL and testbench
==================================

# signal_analyzer

Measurement block at the receiving end of the DDS signal path: it consumes the 32-bit unsigned waveform sample stream produced by the signal generator and recovers the waveform's frequency. It detects rising midscale crossings with hysteresis and averages the period over 2^AVG_LOG2 cycles. It then computes the equivalent phase-accumulator tuning word with a sequential divider and reports peak min/max. It is used for closed-loop self-test of the generator and as a front-end frequency meter.

## Interface
- HYST, 32'h0100_0000: hysteresis half-width around midscale (32'h8000_0000).
- AVG_LOG2, 2: log2 of the number of periods averaged per measurement (range 0–4).
- TIMEOUT, 32'd16_777_216: valid samples allowed per measurement before declaring no signal.
- clk  in  1  system clock, same clock as the signal generator.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  high runs measurements continuously; low forces IDLE.
- sample  in  32  unsigned offset-binary sample, midscale = 32'h8000_0000.
- sample_valid  in  1  sample qualifier; only qualified samples are counted.
- busy  out  1  high in any state other than IDLE.
- result_valid  out  1  single-cycle strobe when new results are loaded.
- period  out  32  averaged period in samples = period_sum >> AVG_LOG2 (truncated).
- tuning_word  out  32  floor(2^(32+AVG_LOG2) / period_sum), saturated to 32'hFFFF_FFFF.
- peak_max / peak_min  out  32 each  extreme samples seen in the measurement window.
- no_signal  out  1  set with result_valid when the measurement timed out.

## Operation
- States: IDLE, ARMING, MEASURE, DIVIDE, DONE.
- Crossing detector:
  - arm flag sets on a valid sample < 32'h8000_0000 − HYST;
  - a valid sample ≥ 32'h8000_0000 + HYST while armed is a rising crossing and clears arm;
  - samples inside the band change nothing.
- IDLE: if enable, clear arm, counters, min = 32'hFFFF_FFFF, max = 0; go to ARMING.
- ARMING: wait for the first crossing, then go to MEASURE with period_sum = 0 and crossing count = 0.
- MEASURE:
  - every valid sample increments period_sum (saturating 32-bit) and updates min/max, the crossing sample included;
  - the 2^AVG_LOG2-th crossing after the first ends the window and starts DIVIDE.
- Timeout counter counts valid samples in ARMING+MEASURE; reaching TIMEOUT goes to DONE with no_signal = 1, period = 0, tuning_word = 0; peaks as captured.
- DIVIDE: restoring divide of dividend 2^(32+AVG_LOG2) by period_sum, one quotient bit per cycle, W = 33+AVG_LOG2 cycles. Any nonzero quotient bit above bit 31 saturates tuning_word to 32'hFFFF_FFFF. Samples are ignored.
- DONE: load all outputs, pulse result_valid, go to IDLE (immediately re-arms if enable is still high).
- enable low in any state: next state IDLE, in-flight measurement discarded, outputs hold last results, no result_valid.
- rst: all outputs 0, state IDLE, arm cleared; rst has priority over enable.

## Timing
- Crossing detect and counting are registered on the clk edge that samples sample_valid; no combinational path from sample to any output.
- Edge accepting the final crossing is edge T. DIVIDE occupies T+1..T+W; result_valid is high in the cycle after edge T+W+1.
- Outputs change only together with result_valid; held stable between strobes.
- Zero wait states between measurements: ARMING starts the cycle after DONE→IDLE.
- Crossing and timeout on the same sample: crossing wins if it completes the window.

## Structure
- Package signal_analyzer_pkg:
  - state enum;
  - MIDSCALE = 32'h8000_0000;
  - default HYST/AVG_LOG2/TIMEOUT values.
- Sub-module seq_divider (parameter width W; start/done handshake; dividend, divisor in; quotient out; busy), instantiated once for DIVIDE.
- Crossing detector, counters and min/max stay inline in signal_analyzer.

## Test plan
- Sawtooth from accumulator with adder 32'h0100_0000, defaults → period 256, tuning_word 32'h0100_0000, peak_min 0, peak_max 32'hFF00_0000, no_signal 0.
- Square wave (500 samples 0, 500 samples 32'hFFFF_FFFF) → period 1000, tuning_word 4294967, peak_min 0, peak_max 32'hFFFF_FFFF.
- Constant 32'h8000_0000, TIMEOUT = 1000 → result_valid after 1000 valid samples, no_signal 1, period 0, tuning_word 0.
- Sawtooth with sample_valid toggling every other cycle, adder 32'h0100_0000 → same results as the first scenario; result_valid exactly W+1 cycles after the final crossing edge.
- enable dropped mid-MEASURE and rst asserted mid-DIVIDE → no result_valid, busy 0 next cycle; after rst all outputs 0; re-enable yields a correct result.
- Triangle with amplitude confined to 32'h8000_0000 ± HYST/2 → no crossings, timeout with no_signal 1.

Source files
------------

// File: rtl/signal_analyzer_pkg.sv
// Shared types and defaults for the signal analyzer: FSM states, midscale
// reference and the default measurement parameters.
package signal_analyzer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMING  = 3'd1,
        S_MEASURE = 3'd2,
        S_DIVIDE  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [31:0] MIDSCALE     = 32'h8000_0000;
    localparam logic [31:0] DEF_HYST     = 32'h0100_0000;
    localparam int          DEF_AVG_LOG2 = 2;
    localparam logic [31:0] DEF_TIMEOUT  = 32'd16_777_216;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, W clocks per divide.
// done is high during the clock whose edge produces the last quotient bit.
module seq_divider #(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_r;
    logic [W-1:0]  dvd_r;
    logic [W-1:0]  quo_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r;

    logic          load_s;
    logic [W-1:0]  src_rem_s;
    logic          src_bit_s;
    logic [W-1:0]  trial_s;
    logic          ge_s;
    logic [W-1:0]  next_rem_s;

    // One restoring step; the bit shifted out of the remainder forces a subtract.
    always_comb begin
        load_s     = start && !busy_r;
        src_rem_s  = load_s ? {W{1'b0}} : rem_r;
        src_bit_s  = load_s ? dividend[W-1] : dvd_r[W-1];
        trial_s    = {src_rem_s[W-2:0], src_bit_s};
        ge_s       = src_rem_s[W-1] || (trial_s >= divisor);
        next_rem_s = ge_s ? (trial_s - divisor) : trial_s;
    end

    // Iteration registers: the load cycle already computes the first quotient bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r  <= {W{1'b0}};
            dvd_r  <= {W{1'b0}};
            quo_r  <= {W{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
        end else if (load_s) begin
            rem_r  <= next_rem_s;
            dvd_r  <= {dividend[W-2:0], 1'b0};
            quo_r  <= {{(W-1){1'b0}}, ge_s};
            cnt_r  <= CW'(W - 1);
            busy_r <= 1'b1;
        end else if (busy_r) begin
            rem_r  <= next_rem_s;
            dvd_r  <= {dvd_r[W-2:0], 1'b0};
            quo_r  <= {quo_r[W-2:0], ge_s};
            cnt_r  <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign quotient = quo_r;
    assign busy     = busy_r;
    assign done     = busy_r && (cnt_r == CW'(1));

endmodule

// File: rtl/signal_analyzer.sv
// Frequency meter: hysteretic midscale crossing detector, averaged period,
// tuning-word division and min/max capture over each measurement window.
module signal_analyzer
    import signal_analyzer_pkg::*;
#(
    parameter logic [31:0] HYST     = DEF_HYST,
    parameter int          AVG_LOG2 = DEF_AVG_LOG2,
    parameter logic [31:0] TIMEOUT  = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] sample,
    input  logic        sample_valid,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] period,
    output logic [31:0] tuning_word,
    output logic [31:0] peak_max,
    output logic [31:0] peak_min,
    output logic        no_signal
);
    localparam int          W        = 33 + AVG_LOG2;
    localparam logic [W-1:0] DIVIDEND = {1'b1, {(W-1){1'b0}}};
    localparam logic [31:0] LO_TH    = MIDSCALE - HYST;
    localparam logic [31:0] HI_TH    = MIDSCALE + HYST;
    localparam logic [4:0]  LAST_X   = 5'((1 << AVG_LOG2) - 1);

    state_t      state_r;
    logic        arm_r;
    logic        tmo_flag_r;
    logic [31:0] sum_r;
    logic [31:0] tmo_r;
    logic [31:0] min_r;
    logic [31:0] max_r;
    logic [4:0]  xcnt_r;

    logic        in_window_s;
    logic        below_s;
    logic        above_s;
    logic        cross_s;
    logic        tmo_hit_s;
    logic        div_start_s;
    logic        div_rst_s;
    logic        div_busy_s;
    logic        div_done_s;
    logic [W-1:0] div_q_s;

    // Qualified-sample classification for crossing detection and timeout.
    always_comb begin
        in_window_s = sample_valid && ((state_r == S_ARMING) || (state_r == S_MEASURE));
        below_s     = (sample < LO_TH);
        above_s     = (sample >= HI_TH);
        cross_s     = in_window_s && arm_r && above_s;
        tmo_hit_s   = in_window_s && ((tmo_r + 32'd1) >= TIMEOUT);
        div_start_s = (state_r == S_DIVIDE) && !div_busy_s;
        div_rst_s   = rst || !enable;
    end

    seq_divider #(.W(W)) u_div (
        .clk      (clk),
        .rst      (div_rst_s),
        .start    (div_start_s),
        .dividend (DIVIDEND),
        .divisor  ({{(W-32){1'b0}}, sum_r}),
        .quotient (div_q_s),
        .busy     (div_busy_s),
        .done     (div_done_s)
    );

    // Measurement FSM, window accumulators and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            arm_r        <= 1'b0;
            tmo_flag_r   <= 1'b0;
            sum_r        <= 32'd0;
            tmo_r        <= 32'd0;
            min_r        <= 32'd0;
            max_r        <= 32'd0;
            xcnt_r       <= 5'd0;
            result_valid <= 1'b0;
            period       <= 32'd0;
            tuning_word  <= 32'd0;
            peak_max     <= 32'd0;
            peak_min     <= 32'd0;
            no_signal    <= 1'b0;
        end else if (!enable) begin
            state_r      <= S_IDLE;
            arm_r        <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (in_window_s) begin
                if (below_s) begin
                    arm_r <= 1'b1;
                end else if (above_s) begin
                    arm_r <= 1'b0;
                end
                tmo_r <= tmo_r + 32'd1;
            end
            case (state_r)
                S_IDLE: begin
                    arm_r      <= 1'b0;
                    tmo_flag_r <= 1'b0;
                    sum_r      <= 32'd0;
                    tmo_r      <= 32'd0;
                    xcnt_r     <= 5'd0;
                    min_r      <= 32'hFFFF_FFFF;
                    max_r      <= 32'd0;
                    state_r    <= S_ARMING;
                end
                S_ARMING: begin
                    if (tmo_hit_s) begin
                        tmo_flag_r <= 1'b1;
                        state_r    <= S_DONE;
                    end else if (cross_s) begin
                        sum_r   <= 32'd0;
                        xcnt_r  <= 5'd0;
                        state_r <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (sample_valid) begin
                        sum_r <= sat_inc32(sum_r);
                        if (sample < min_r) min_r <= sample;
                        if (sample > max_r) max_r <= sample;
                    end
                    // A window-completing crossing beats a simultaneous timeout.
                    if (cross_s && (xcnt_r == LAST_X)) begin
                        state_r <= S_DIVIDE;
                    end else if (tmo_hit_s) begin
                        tmo_flag_r <= 1'b1;
                        state_r    <= S_DONE;
                    end else if (cross_s) begin
                        xcnt_r <= xcnt_r + 5'd1;
                    end
                end
                S_DIVIDE: begin
                    if (div_done_s) state_r <= S_DONE;
                end
                S_DONE: begin
                    result_valid <= 1'b1;
                    peak_min     <= min_r;
                    peak_max     <= max_r;
                    no_signal    <= tmo_flag_r;
                    if (tmo_flag_r) begin
                        period      <= 32'd0;
                        tuning_word <= 32'd0;
                    end else begin
                        period      <= sum_r >> AVG_LOG2;
                        tuning_word <= (|div_q_s[W-1:32]) ? 32'hFFFF_FFFF : div_q_s[31:0];
                    end
                    state_r <= S_IDLE;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_r != S_IDLE);

endmodule

// File: tb/tb_signal_analyzer.sv
// Directed scoreboard bench for signal_analyzer: one default instance and one
// with a short timeout share the sample stream.
module tb_signal_analyzer;

    typedef struct packed {
        logic [31:0] period;
        logic [31:0] tw;
        logic [31:0] pmin;
        logic [31:0] pmax;
        logic        nosig;
    } exp_t;

    localparam logic [31:0] MID = 32'h8000_0000;
    localparam int LAT = 36;  // W+1 with AVG_LOG2 = 2

    logic        clk = 1'b0;
    logic        rst;
    logic        en_main, en_tmo;
    logic [31:0] sample;
    logic        sample_valid;

    logic        m_busy, m_rv, m_nosig;
    logic [31:0] m_period, m_tw, m_pmax, m_pmin;
    logic        t_busy, t_rv, t_nosig;
    logic [31:0] t_period, t_tw, t_pmax, t_pmin;

    exp_t q_main[$];
    exp_t q_tmo[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_rv_main = 0;
    int n_rv_tmo = 0;
    int rv_cyc_main = 0;
    int rv_cyc_tmo = 0;
    int last_valid_cyc = 0;
    logic [31:0] acc;

    always #5 clk = ~clk;

    signal_analyzer u_main (
        .clk(clk), .rst(rst), .enable(en_main), .sample(sample), .sample_valid(sample_valid),
        .busy(m_busy), .result_valid(m_rv), .period(m_period), .tuning_word(m_tw),
        .peak_max(m_pmax), .peak_min(m_pmin), .no_signal(m_nosig)
    );

    signal_analyzer #(.TIMEOUT(32'd1000)) u_tmo (
        .clk(clk), .rst(rst), .enable(en_tmo), .sample(sample), .sample_valid(sample_valid),
        .busy(t_busy), .result_valid(t_rv), .period(t_period), .tuning_word(t_tw),
        .peak_max(t_pmax), .peak_min(t_pmin), .no_signal(t_nosig)
    );

    function automatic logic [31:0] tw_model(input logic [63:0] sum);
        logic [63:0] q;
        q = 64'h4_0000_0000 / sum;
        return (q > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cmp_result(input string who, input exp_t e, input logic [31:0] p,
                              input logic [31:0] tw, input logic [31:0] mn,
                              input logic [31:0] mx, input logic ns);
        check({who, "_period"}, p, e.period);
        check({who, "_tuning_word"}, tw, e.tw);
        check({who, "_peak_min"}, mn, e.pmin);
        check({who, "_peak_max"}, mx, e.pmax);
        check({who, "_no_signal"}, {31'd0, ns}, {31'd0, e.nosig});
    endtask

    // Drive one cycle, then score any result strobe against the queues.
    task automatic tick(input logic [31:0] s, input logic v);
        exp_t e;
        sample = s;
        sample_valid = v;
        @(posedge clk);
        #1;
        cyc++;
        if (m_rv) begin
            n_rv_main++;
            rv_cyc_main = cyc;
            if (q_main.size() == 0) begin
                check("main_unexpected_strobe", {31'd0, m_rv}, 32'd0);
            end else begin
                e = q_main.pop_front();
                cmp_result("main", e, m_period, m_tw, m_pmin, m_pmax, m_nosig);
            end
        end
        if (t_rv) begin
            n_rv_tmo++;
            rv_cyc_tmo = cyc;
            if (q_tmo.size() == 0) begin
                check("tmo_unexpected_strobe", {31'd0, t_rv}, 32'd0);
            end else begin
                e = q_tmo.pop_front();
                cmp_result("tmo", e, t_period, t_tw, t_pmin, t_pmax, t_nosig);
            end
        end
    endtask

    task automatic saw_stream(input bit toggle, input int n_valid);
        for (int i = 0; i < n_valid; i++) begin
            tick(acc, 1'b1);
            last_valid_cyc = cyc;
            acc = acc + 32'h0100_0000;
            if (toggle) tick(32'hFFFF_FFFF, 1'b0);
        end
    endtask

    task automatic wait_main(input int budget, input int start_cnt);
        int k;
        k = 0;
        while ((n_rv_main == start_cnt) && (k < budget)) begin
            tick(32'd0, 1'b0);
            k++;
        end
        check("main_strobe_count", 32'(n_rv_main - start_cnt), 32'd1);
    endtask

    initial begin
        int start_cnt;
        int k;
        exp_t e_saw, e_sq, e_nosig;
        e_saw   = '{period: 32'd256, tw: tw_model(64'd1024), pmin: 32'd0,
                    pmax: 32'hFF00_0000, nosig: 1'b0};
        e_sq    = '{period: 32'd1000, tw: tw_model(64'd4000), pmin: 32'd0,
                    pmax: 32'hFFFF_FFFF, nosig: 1'b0};
        e_nosig = '{period: 32'd0, tw: 32'd0, pmin: 32'hFFFF_FFFF,
                    pmax: 32'd0, nosig: 1'b1};

        rst = 1'b1; en_main = 1'b1; en_tmo = 1'b0; acc = 32'd0;
        tick(32'd0, 1'b0);
        tick(32'd0, 1'b0);
        check("reset_busy", {31'd0, m_busy}, 32'd0);
        check("reset_period", m_period, 32'd0);
        check("reset_tuning_word", m_tw, 32'd0);
        check("reset_peak_min", m_pmin, 32'd0);
        check("reset_peak_max", m_pmax, 32'd0);
        check("reset_no_signal", {31'd0, m_nosig}, 32'd0);
        rst = 1'b0; en_main = 1'b0;
        tick(32'd0, 1'b0);

        // Sawtooth, every sample valid.
        en_main = 1'b1;
        tick(32'd0, 1'b0);
        check("arming_busy", {31'd0, m_busy}, 32'd1);
        q_main.push_back(e_saw);
        acc = 32'd0; start_cnt = n_rv_main;
        saw_stream(1'b0, 1154);
        wait_main(200, start_cnt);
        check("saw_latency", 32'(rv_cyc_main - last_valid_cyc), 32'(LAT));
        en_main = 1'b0;
        tick(32'd0, 1'b0);
        check("disable_busy", {31'd0, m_busy}, 32'd0);

        // Sawtooth with sample_valid on every other cycle.
        en_main = 1'b1;
        tick(32'd0, 1'b0);
        q_main.push_back(e_saw);
        acc = 32'd0; start_cnt = n_rv_main;
        saw_stream(1'b1, 1154);
        wait_main(200, start_cnt);
        check("toggle_latency", 32'(rv_cyc_main - last_valid_cyc), 32'(LAT));
        en_main = 1'b0;
        tick(32'd0, 1'b0);

        // Square wave, 500 low / 500 high.
        en_main = 1'b1;
        tick(32'd0, 1'b0);
        q_main.push_back(e_sq);
        start_cnt = n_rv_main; k = 0;
        while ((n_rv_main == start_cnt) && (k < 4700)) begin
            tick(((k / 500) % 2 == 1) ? 32'hFFFF_FFFF : 32'd0, 1'b1);
            k++;
        end
        check("square_strobe_count", 32'(n_rv_main - start_cnt), 32'd1);
        en_main = 1'b0;
        tick(32'd0, 1'b0);

        // Constant midscale on the short-timeout instance.
        en_tmo = 1'b1;
        tick(32'd0, 1'b0);
        q_tmo.push_back(e_nosig);
        start_cnt = n_rv_tmo; k = 0;
        while ((n_rv_tmo == start_cnt) && (k < 1200)) begin
            tick(MID, 1'b1);
            k++;
        end
        check("const_timeout_ticks", 32'(k), 32'd1001);
        en_tmo = 1'b0;
        tick(32'd0, 1'b0);

        // Small triangle confined inside the hysteresis band.
        en_tmo = 1'b1;
        tick(32'd0, 1'b0);
        q_tmo.push_back(e_nosig);
        start_cnt = n_rv_tmo; k = 0;
        while ((n_rv_tmo == start_cnt) && (k < 1200)) begin
            int ph;
            ph = k % 32;
            ph = (ph < 16) ? ph : 32 - ph;
            tick(MID - 32'h0080_0000 + 32'(ph) * 32'h0010_0000, 1'b1);
            k++;
        end
        check("triangle_timeout_ticks", 32'(k), 32'd1001);
        en_tmo = 1'b0;
        tick(32'd0, 1'b0);

        // Abort mid-MEASURE by enable, then mid-DIVIDE by reset.
        en_main = 1'b1;
        tick(32'd0, 1'b0);
        acc = 32'd0;
        saw_stream(1'b0, 500);
        en_main = 1'b0;
        tick(32'd0, 1'b0);
        check("abort_busy", {31'd0, m_busy}, 32'd0);
        check("abort_no_strobe", {31'd0, m_rv}, 32'd0);
        check("abort_hold_period", m_period, 32'd1000);
        check("abort_hold_tw", m_tw, tw_model(64'd4000));
        en_main = 1'b1;
        tick(32'd0, 1'b0);
        acc = 32'd0;
        saw_stream(1'b0, 1154);
        for (int i = 0; i < 5; i++) tick(32'd0, 1'b0);
        check("divide_busy", {31'd0, m_busy}, 32'd1);
        rst = 1'b1;
        tick(32'd0, 1'b0);
        check("rst_busy", {31'd0, m_busy}, 32'd0);
        check("rst_no_strobe", {31'd0, m_rv}, 32'd0);
        check("rst_period", m_period, 32'd0);
        check("rst_tuning_word", m_tw, 32'd0);
        check("rst_peak_max", m_pmax, 32'd0);
        check("rst_no_signal", {31'd0, m_nosig}, 32'd0);
        rst = 1'b0; en_main = 1'b0;
        tick(32'd0, 1'b0);
        en_main = 1'b1;
        tick(32'd0, 1'b0);
        q_main.push_back(e_saw);
        acc = 32'd0; start_cnt = n_rv_main;
        saw_stream(1'b0, 1154);
        wait_main(200, start_cnt);
        en_main = 1'b0;
        for (int i = 0; i < 4; i++) tick(32'd0, 1'b0);

        check("main_queue_drained", 32'(q_main.size()), 32'd0);
        check("tmo_queue_drained", 32'(q_tmo.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
